// File: rtl/rec_bank_arb.sv
// Four-bank reconstruction-memory arbiter between rec write-back (wr), prediction read (pre) and
// entropy-coder read (ec). Define REC_ARB_OUT_REG_EN to add an output register stage (read latency 2).
module rec_bank_arb #(
  parameter int AW         = 7,
  parameter int DW         = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_req_i,
  input  logic [1:0]      wr_bank_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [DW-1:0]   wr_data_i,
  output logic            wr_ack_o,
  input  logic            pre_req_i,
  input  logic [1:0]      pre_bank_i,
  input  logic [AW-1:0]   pre_addr_i,
  output logic            pre_ack_o,
  output logic            pre_vld_o,
  output logic [DW-1:0]   pre_data_o,
  input  logic            ec_req_i,
  input  logic [1:0]      ec_bank_i,
  input  logic [AW-1:0]   ec_addr_i,
  output logic            ec_ack_o,
  output logic            ec_vld_o,
  output logic [DW-1:0]   ec_data_o,
  output logic [3:0]      mem_en_o,
  output logic [3:0]      mem_we_o,
  output logic [4*AW-1:0] mem_addr_o,
  output logic [4*DW-1:0] mem_wdata_o,
  input  logic [4*DW-1:0] mem_rdata_i
);

  localparam logic [3:0] STV_MAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_PRE  = 2'd2,
    GNT_EC   = 2'd3
  } gnt_e;

  // Forced readers beat wr (pre first); otherwise wr, then round-robin between the readers.
  function automatic gnt_e pick_winner(input logic w, input logic p, input logic e,
                                       input logic pf, input logic ef, input logic rr);
    gnt_e g;
    if (p && pf) begin
      g = GNT_PRE;
    end else if (e && ef) begin
      g = GNT_EC;
    end else if (w) begin
      g = GNT_WR;
    end else if (p && e) begin
      g = rr ? GNT_EC : GNT_PRE;
    end else if (p) begin
      g = GNT_PRE;
    end else if (e) begin
      g = GNT_EC;
    end else begin
      g = GNT_NONE;
    end
    return g;
  endfunction

  logic [3:0]    w_s, p_s, e_s;
  gnt_e          gnt_s [4];
  logic          pre_forced_s, ec_forced_s;
  logic          pre_wr_blk_s, ec_wr_blk_s;
  logic [3:0]    rr_q, rr_d;
  logic [3:0]    pre_stv_q, pre_stv_d, ec_stv_q, ec_stv_d;
  logic          pre_vld_q, pre_vld_d, ec_vld_q, ec_vld_d;
  logic [1:0]    pre_bank_q, pre_bank_d, ec_bank_q, ec_bank_d;
  logic [DW-1:0] pre_rd_s, ec_rd_s;

  assign w_s = wr_req_i  ? (4'b0001 << wr_bank_i)  : 4'b0000;
  assign p_s = pre_req_i ? (4'b0001 << pre_bank_i) : 4'b0000;
  assign e_s = ec_req_i  ? (4'b0001 << ec_bank_i)  : 4'b0000;

  assign pre_forced_s = (pre_stv_q == STV_MAX);
  assign ec_forced_s  = (ec_stv_q == STV_MAX);

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      if (rst) begin
        gnt_s[b] = GNT_NONE;
      end else begin
        gnt_s[b] = pick_winner(w_s[b], p_s[b], e_s[b], pre_forced_s, ec_forced_s, rr_q[b]);
      end
    end
  end

  always_comb begin
    wr_ack_o     = 1'b0;
    pre_ack_o    = 1'b0;
    ec_ack_o     = 1'b0;
    mem_en_o     = 4'b0000;
    mem_we_o     = 4'b0000;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    rr_d         = rr_q;
    pre_wr_blk_s = 1'b0;
    ec_wr_blk_s  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      case (gnt_s[b])
        GNT_WR: begin
          wr_ack_o                = 1'b1;
          mem_en_o[b]             = 1'b1;
          mem_we_o[b]             = 1'b1;
          mem_addr_o[b*AW +: AW]  = wr_addr_i;
          mem_wdata_o[b*DW +: DW] = wr_data_i;
          // Only a refusal caused by wr counts towards starvation.
          pre_wr_blk_s            = pre_wr_blk_s | p_s[b];
          ec_wr_blk_s             = ec_wr_blk_s | e_s[b];
        end
        GNT_PRE: begin
          pre_ack_o              = 1'b1;
          mem_en_o[b]            = 1'b1;
          mem_addr_o[b*AW +: AW] = pre_addr_i;
          if (p_s[b] && e_s[b]) begin
            rr_d[b] = 1'b1;
          end else begin
            rr_d[b] = rr_q[b];
          end
        end
        GNT_EC: begin
          ec_ack_o               = 1'b1;
          mem_en_o[b]            = 1'b1;
          mem_addr_o[b*AW +: AW] = ec_addr_i;
          if (p_s[b] && e_s[b]) begin
            rr_d[b] = 1'b0;
          end else begin
            rr_d[b] = rr_q[b];
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    if (!pre_req_i || pre_ack_o) begin
      pre_stv_d = 4'd0;
    end else if (pre_wr_blk_s && (pre_stv_q != STV_MAX)) begin
      pre_stv_d = pre_stv_q + 4'd1;
    end else begin
      pre_stv_d = pre_stv_q;
    end
    if (!ec_req_i || ec_ack_o) begin
      ec_stv_d = 4'd0;
    end else if (ec_wr_blk_s && (ec_stv_q != STV_MAX)) begin
      ec_stv_d = ec_stv_q + 4'd1;
    end else begin
      ec_stv_d = ec_stv_q;
    end
    pre_vld_d  = pre_ack_o;
    ec_vld_d   = ec_ack_o;
    pre_bank_d = pre_ack_o ? pre_bank_i : pre_bank_q;
    ec_bank_d  = ec_ack_o ? ec_bank_i : ec_bank_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= 4'd0;
      pre_stv_q  <= 4'd0;
      ec_stv_q   <= 4'd0;
      pre_vld_q  <= 1'b0;
      ec_vld_q   <= 1'b0;
      pre_bank_q <= 2'd0;
      ec_bank_q  <= 2'd0;
    end else begin
      rr_q       <= rr_d;
      pre_stv_q  <= pre_stv_d;
      ec_stv_q   <= ec_stv_d;
      pre_vld_q  <= pre_vld_d;
      ec_vld_q   <= ec_vld_d;
      pre_bank_q <= pre_bank_d;
      ec_bank_q  <= ec_bank_d;
    end
  end

  assign pre_rd_s = pre_vld_q ? mem_rdata_i[pre_bank_q*DW +: DW] : '0;
  assign ec_rd_s  = ec_vld_q ? mem_rdata_i[ec_bank_q*DW +: DW] : '0;

`ifdef REC_ARB_OUT_REG_EN
  logic          pre_vld2_q, pre_vld2_d, ec_vld2_q, ec_vld2_d;
  logic [DW-1:0] pre_data2_q, pre_data2_d, ec_data2_q, ec_data2_d;

  always_comb begin
    pre_vld2_d  = pre_vld_q;
    ec_vld2_d   = ec_vld_q;
    pre_data2_d = pre_rd_s;
    ec_data2_d  = ec_rd_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_vld2_q  <= 1'b0;
      ec_vld2_q   <= 1'b0;
      pre_data2_q <= '0;
      ec_data2_q  <= '0;
    end else begin
      pre_vld2_q  <= pre_vld2_d;
      ec_vld2_q   <= ec_vld2_d;
      pre_data2_q <= pre_data2_d;
      ec_data2_q  <= ec_data2_d;
    end
  end

  assign pre_vld_o  = pre_vld2_q & ~rst;
  assign ec_vld_o   = ec_vld2_q & ~rst;
  assign pre_data_o = (pre_vld2_q && !rst) ? pre_data2_q : '0;
  assign ec_data_o  = (ec_vld2_q && !rst) ? ec_data2_q : '0;
`else
  // Outputs are forced quiet while rst is high so an in-flight read is dropped immediately.
  assign pre_vld_o  = pre_vld_q & ~rst;
  assign ec_vld_o   = ec_vld_q & ~rst;
  assign pre_data_o = (pre_vld_q && !rst) ? pre_rd_s : '0;
  assign ec_data_o  = (ec_vld_q && !rst) ? ec_rd_s : '0;
`endif

endmodule

// File: tb/tb_rec_bank_arb.sv
// Self-checking bench for rec_bank_arb: per-scenario tasks plus a read-return scoreboard.
module tb_rec_bank_arb;
  localparam int AW  = 7;
  localparam int DW  = 128;
  localparam int STV = 4;
`ifdef REC_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_req_i, pre_req_i, ec_req_i;
  logic [1:0]      wr_bank_i, pre_bank_i, ec_bank_i;
  logic [AW-1:0]   wr_addr_i, pre_addr_i, ec_addr_i;
  logic [DW-1:0]   wr_data_i;
  logic            wr_ack_o, pre_ack_o, ec_ack_o, pre_vld_o, ec_vld_o;
  logic [DW-1:0]   pre_data_o, ec_data_o;
  logic [3:0]      mem_en_o, mem_we_o;
  logic [4*AW-1:0] mem_addr_o;
  logic [4*DW-1:0] mem_wdata_o, mem_rdata_i;
  logic [DW-1:0]   rdata [4];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t pre_sb[$];
  exp_t ec_sb[$];

  rec_bank_arb #(.AW(AW), .DW(DW), .STARVE_MAX(STV)) dut (
    .clk(clk), .rst(rst),
    .wr_req_i(wr_req_i), .wr_bank_i(wr_bank_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_ack_o(wr_ack_o),
    .pre_req_i(pre_req_i), .pre_bank_i(pre_bank_i), .pre_addr_i(pre_addr_i),
    .pre_ack_o(pre_ack_o), .pre_vld_o(pre_vld_o), .pre_data_o(pre_data_o),
    .ec_req_i(ec_req_i), .ec_bank_i(ec_bank_i), .ec_addr_i(ec_addr_i),
    .ec_ack_o(ec_ack_o), .ec_vld_o(ec_vld_o), .ec_data_o(ec_data_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input int b, input int a);
    logic [31:0] w;
    w = {8'(b) + 8'h30, 8'(a), 16'hC3A5 ^ 16'(a * 7)};
    return {w, ~w, w ^ 32'h0F0F_0F0F, w + 32'd1};
  endfunction

  // Bank macro model: 1-cycle read latency, contents are a fixed address pattern.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (rst) rdata[b] <= '0;
      else if (mem_en_o[b] && !mem_we_o[b]) rdata[b] <= pat(b, int'(mem_addr_o[b*AW +: AW]));
    end
  end
  assign mem_rdata_i = {rdata[3], rdata[2], rdata[1], rdata[0]};

  task automatic set_wr(input logic r, input logic [1:0] b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req_i = r; wr_bank_i = b; wr_addr_i = a; wr_data_i = d;
  endtask
  task automatic set_pre(input logic r, input logic [1:0] b, input logic [AW-1:0] a);
    pre_req_i = r; pre_bank_i = b; pre_addr_i = a;
  endtask
  task automatic set_ec(input logic r, input logic [1:0] b, input logic [AW-1:0] a);
    ec_req_i = r; ec_bank_i = b; ec_addr_i = a;
  endtask
  task automatic clr_req();
    set_wr(1'b0, 2'd0, 7'd0, 128'd0); set_pre(1'b0, 2'd0, 7'd0); set_ec(1'b0, 2'd0, 7'd0);
  endtask
  task automatic push_pre(input int b, input int a);
    exp_t e; e.data = pat(b, a); e.due = cyc + LAT; pre_sb.push_back(e);
  endtask
  task automatic push_ec(input int b, input int a);
    exp_t e; e.data = pat(b, a); e.due = cyc + LAT; ec_sb.push_back(e);
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); clr_req(); end
  endtask

  // Read-return scoreboard: every vld must match the oldest expected read, on its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        if (pre_vld_o === 1'b1) begin
          checks++;
          if (pre_sb.size() == 0) begin
            errors++; $display("FAIL pre_vld_unexpected cycle=%0d", cyc);
          end else begin
            e = pre_sb.pop_front();
            if (pre_data_o !== e.data || cyc != e.due) begin
              errors++;
              $display("FAIL pre_rdata got=%h@%0d exp=%h@%0d", pre_data_o, cyc, e.data, e.due);
            end
          end
        end else if (pre_sb.size() != 0 && pre_sb[0].due <= cyc) begin
          checks++; errors++;
          $display("FAIL pre_vld_missing got=%b exp=1 due=%0d", pre_vld_o, pre_sb[0].due);
          void'(pre_sb.pop_front());
        end
        if (ec_vld_o === 1'b1) begin
          checks++;
          if (ec_sb.size() == 0) begin
            errors++; $display("FAIL ec_vld_unexpected cycle=%0d", cyc);
          end else begin
            e = ec_sb.pop_front();
            if (ec_data_o !== e.data || cyc != e.due) begin
              errors++;
              $display("FAIL ec_rdata got=%h@%0d exp=%h@%0d", ec_data_o, cyc, e.data, e.due);
            end
          end
        end else if (ec_sb.size() != 0 && ec_sb[0].due <= cyc) begin
          checks++; errors++;
          $display("FAIL ec_vld_missing got=%b exp=1 due=%0d", ec_vld_o, ec_sb[0].due);
          void'(ec_sb.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_wr(1'b1, 2'd0, 7'h45, 128'd1); set_pre(1'b1, 2'd1, 7'd1); set_ec(1'b1, 2'd2, 7'd2);
      #1;
      checks++;
      if ({wr_ack_o, pre_ack_o, ec_ack_o, mem_en_o, mem_we_o, pre_vld_o, ec_vld_o} !== 13'd0) begin
        errors++;
        $display("FAIL reset_quiet got=%b%b%b en=%b we=%b vld=%b%b exp=all 0",
                 wr_ack_o, pre_ack_o, ec_ack_o, mem_en_o, mem_we_o, pre_vld_o, ec_vld_o);
      end
      checks++;
      if ({pre_data_o, ec_data_o} !== 256'd0) begin
        errors++; $display("FAIL reset_data got=%h %h exp=0", pre_data_o, ec_data_o);
      end
    end
    @(negedge clk); rst = 1'b0; clr_req();
  endtask

  task automatic test_same_bank();
    logic [DW-1:0] wd;
    wd = {4{32'hDEAD_0001}};
    @(negedge clk);
    set_wr(1'b1, 2'd2, 7'h41, wd); set_pre(1'b1, 2'd2, 7'd3); set_ec(1'b1, 2'd2, 7'd4);
    #1;
    checks++;
    if ({wr_ack_o, pre_ack_o, ec_ack_o} !== 3'b100 || mem_en_o !== 4'b0100 || mem_we_o !== 4'b0100) begin
      errors++;
      $display("FAIL same_bank_wr got=%b%b%b en=%b we=%b exp=100 en=0100 we=0100",
               wr_ack_o, pre_ack_o, ec_ack_o, mem_en_o, mem_we_o);
    end
    checks++;
    if (mem_addr_o[2*AW +: AW] !== 7'h41 || mem_wdata_o[2*DW +: DW] !== wd) begin
      errors++; $display("FAIL same_bank_wlane got=%h/%h exp=41/%h", mem_addr_o[2*AW +: AW], mem_wdata_o[2*DW +: DW], wd);
    end
    @(negedge clk); set_wr(1'b0, 2'd0, 7'd0, 128'd0); #1;
    checks++;
    if ({wr_ack_o, pre_ack_o, ec_ack_o} !== 3'b010) begin
      errors++; $display("FAIL same_bank_pre got=%b%b%b exp=010", wr_ack_o, pre_ack_o, ec_ack_o);
    end
    push_pre(2, 3);
    @(negedge clk); set_pre(1'b0, 2'd0, 7'd0); #1;
    checks++;
    if ({wr_ack_o, pre_ack_o, ec_ack_o} !== 3'b001) begin
      errors++; $display("FAIL same_bank_ec got=%b%b%b exp=001", wr_ack_o, pre_ack_o, ec_ack_o);
    end
    push_ec(2, 4);
  endtask

  task automatic test_parallel();
    logic [DW-1:0] wd;
    wd = {4{32'h1234_5678}};
    @(negedge clk);
    set_wr(1'b1, 2'd3, 7'h42, wd); set_pre(1'b1, 2'd0, 7'd5); set_ec(1'b1, 2'd1, 7'd9);
    #1;
    checks++;
    if ({wr_ack_o, pre_ack_o, ec_ack_o} !== 3'b111 || mem_en_o !== 4'b1011 || mem_we_o !== 4'b1000) begin
      errors++;
      $display("FAIL parallel_acks got=%b%b%b en=%b we=%b exp=111 en=1011 we=1000",
               wr_ack_o, pre_ack_o, ec_ack_o, mem_en_o, mem_we_o);
    end
    checks++;
    if ({mem_addr_o[3*AW +: AW], mem_addr_o[2*AW +: AW], mem_addr_o[1*AW +: AW], mem_addr_o[0 +: AW]}
        !== {7'h42, 7'h00, 7'd9, 7'd5}) begin
      errors++; $display("FAIL parallel_addr got=%h exp=42/00/09/05", mem_addr_o);
    end
    checks++;
    if (mem_wdata_o[3*DW +: DW] !== wd || mem_wdata_o[0 +: DW] !== 128'd0) begin
      errors++; $display("FAIL parallel_wdata got=%h exp=%h", mem_wdata_o[3*DW +: DW], wd);
    end
    push_pre(0, 5); push_ec(1, 9);
  endtask

  task automatic test_starve();
    for (int i = 0; i <= STV; i++) begin
      @(negedge clk);
      set_wr(1'b1, 2'd1, 7'h43, {4{32'hA5A5_0000}}); set_pre(1'b1, 2'd1, 7'd11);
      #1;
      checks++;
      if (i < STV && {wr_ack_o, pre_ack_o} !== 2'b10) begin
        errors++; $display("FAIL starve_block%0d got=%b%b exp=10", i, wr_ack_o, pre_ack_o);
      end else if (i == STV && {wr_ack_o, pre_ack_o} !== 2'b01) begin
        errors++; $display("FAIL starve_force got=%b%b exp=01", wr_ack_o, pre_ack_o);
      end
    end
    push_pre(1, 11);
    @(negedge clk); set_pre(1'b0, 2'd0, 7'd0); #1;
    checks++;
    if ({wr_ack_o, pre_ack_o} !== 2'b10) begin
      errors++; $display("FAIL starve_wr_resume got=%b%b exp=10", wr_ack_o, pre_ack_o);
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_pre(1'b1, 2'd0, 7'd20); set_ec(1'b1, 2'd0, 7'd21);
      #1;
      checks++;
      if ({pre_ack_o, ec_ack_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01) || dut.rr_q[0] !== 1'(i % 2)) begin
        errors++;
        $display("FAIL rr_cycle%0d got=%b%b rr=%b exp=%0d", i, pre_ack_o, ec_ack_o, dut.rr_q[0], i % 2);
      end
      if (i % 2 == 0) push_pre(0, 20);
      else push_ec(0, 21);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_wr(1'b1, 2'd3, 7'h44, {4{32'h0BAD_CAFE}}); set_pre(1'b1, 2'd1, 7'd12); set_ec(1'b1, 2'd3, 7'd13);
    #1;
    checks++;
    if ({wr_ack_o, pre_ack_o, ec_ack_o} !== 3'b110) begin
      errors++; $display("FAIL rstmid_pre got=%b%b%b exp=110", wr_ack_o, pre_ack_o, ec_ack_o);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rst = 1'b1; #1;
      checks++;
      if ({wr_ack_o, pre_ack_o, ec_ack_o, mem_en_o, mem_we_o, pre_vld_o, ec_vld_o} !== 13'd0) begin
        errors++;
        $display("FAIL rstmid_quiet%0d got=%b%b%b en=%b we=%b vld=%b%b exp=all 0",
                 i, wr_ack_o, pre_ack_o, ec_ack_o, mem_en_o, mem_we_o, pre_vld_o, ec_vld_o);
      end
    end
    @(negedge clk); rst = 1'b0; clr_req(); #1;
    checks++;
    if (dut.rr_q !== 4'd0 || dut.pre_stv_q !== 4'd0 || dut.ec_stv_q !== 4'd0 || pre_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state got=rr %b stv %0d/%0d vld %b exp=0", dut.rr_q, dut.pre_stv_q, dut.ec_stv_q, pre_vld_o);
    end
    @(negedge clk); set_pre(1'b1, 2'd2, 7'd14); set_ec(1'b1, 2'd2, 7'd15); #1;
    checks++;
    if ({pre_ack_o, ec_ack_o} !== 2'b10) begin
      errors++; $display("FAIL rstmid_rr_pre got=%b%b exp=10", pre_ack_o, ec_ack_o);
    end
    push_pre(2, 14);
    @(negedge clk); set_pre(1'b0, 2'd0, 7'd0); #1;
    checks++;
    if ({pre_ack_o, ec_ack_o} !== 2'b01) begin
      errors++; $display("FAIL rstmid_rr_ec got=%b%b exp=01", pre_ack_o, ec_ack_o);
    end
    push_ec(2, 15);
  endtask

  task automatic test_ec_latency();
    @(negedge clk); set_ec(1'b1, 2'd2, 7'd30); #1;
    checks++;
    if (ec_ack_o !== 1'b1) begin
      errors++; $display("FAIL ec_lat_ack got=%b exp=1", ec_ack_o);
    end
    push_ec(2, 30);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk); clr_req(); #1;
      checks++;
      if (ec_vld_o !== 1'(LAT == k)) begin
        errors++; $display("FAIL ec_lat_t%0d got=%b exp=%b", k, ec_vld_o, 1'(LAT == k));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); set_pre(1'b1, 2'd3, 7'(i)); set_ec(1'b1, 2'd0, 7'(40 + i)); #1;
      checks++;
      if ({pre_ack_o, ec_ack_o} !== 2'b11 || mem_en_o !== 4'b1001 || mem_we_o !== 4'b0000) begin
        errors++; $display("FAIL b2b_%0d got=%b%b en=%b exp=11 en=1001", i, pre_ack_o, ec_ack_o, mem_en_o);
      end
      push_pre(3, i); push_ec(0, 40 + i);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr_req();
    test_reset();
    test_same_bank();
    idle(3);
    test_parallel();
    idle(3);
    test_starve();
    idle(3);
    test_round_robin();
    idle(4);
    test_reset_mid();
    idle(3);
    test_ec_latency();
    idle(3);
    test_back_to_back();
    idle(5);
    checks++;
    if (pre_sb.size() != 0 || ec_sb.size() != 0) begin
      errors++; $display("FAIL sb_drain got=%0d/%0d exp=0/0", pre_sb.size(), ec_sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rec_bank_arb.md
Name: rec_bank_arb

Overview:
- Arbitrates single-port access to the 4 reconstruction-memory banks between three requesters.
- Requesters: rec write-back (wr), prediction read (pre) and entropy-coder read (ec).
- Bank indices come from the reconstruction TLB (2-bit bank per request).
- Per-bank priority: wr > {pre, ec}, with round-robin between pre and ec and a starvation guard against continuous wr.
- Drives the bank macros directly and returns read data with fixed latency.

Parameters:
AW, 7, per-bank word address width
DW, 128, bank data width (bits)
STARVE_MAX, 4, consecutive wr-blocked cycles a reader tolerates before forcing its grant (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_req_i  in  1  write request, held until ack
wr_bank_i  in  2  target bank
wr_addr_i  in  AW  word address
wr_data_i  in  DW  write data
wr_ack_o  out  1  write granted this cycle (combinational)
pre_req_i  in  1  pre read request, held until ack
pre_bank_i  in  2  target bank
pre_addr_i  in  AW  word address
pre_ack_o  out  1  pre read granted this cycle (combinational)
pre_vld_o  out  1  pre read data valid
pre_data_o  out  DW  pre read data
ec_req_i  in  1  ec read request, held until ack
ec_bank_i  in  2  target bank
ec_addr_i  in  AW  word address
ec_ack_o  out  1  ec read granted (combinational)
ec_vld_o  out  1  ec read data valid
ec_data_o  out  DW  ec read data
mem_en_o  out  4  per-bank access enable, active high
mem_we_o  out  4  per-bank write enable, active high
mem_addr_o  out  4*AW  per-bank address, bank b at [b*AW +: AW]
mem_wdata_o  out  4*DW  per-bank write data
mem_rdata_i  in  4*DW  per-bank read data, 1-cycle latency after mem_en_o

Behaviour:
- One clock (clk); synchronous active-high reset (rst). All state clears on the clk edge while rst=1. During rst all acks, mem_en_o, mem_we_o and vld outputs are 0.
- Reset values:
  - vld outputs 0; data outputs 0.
  - rr_r[3:0] = 0, meaning pre is preferred on every bank.
  - Starvation counters pre_stv_r and ec_stv_r (4 bits each) = 0.
- Grant per cycle, evaluated independently for each bank b:
  - Let W, P, E = the requester is active with bank==b.
  - A reader is forced when its stv counter == STARVE_MAX. A forced reader beats wr.
  - If both readers are forced, pre wins.
  - Otherwise, W granted if present.
  - Otherwise, if P and E are both present, rr_r[b] picks: 0 = pre, 1 = ec.
  - Otherwise, the single requester present is granted.
- A requester targets one bank, so it receives at most one grant. Requesters on different banks are all granted in the same cycle.
- rr_r[b] update: toggles only when P and E both requested bank b and one of them was granted. It becomes 1 after a pre grant and 0 after an ec grant.
- Starvation counters:
  - pre_stv_r increments when pre_req_i=1 and pre is refused because wr held its bank; saturates at STARVE_MAX.
  - It clears on a pre grant or when pre_req_i=0.
  - A refusal caused by ec (round-robin) does not increment it.
  - ec_stv_r behaves identically.
- Memory drive:
  - For each granted bank, mem_en_o[b]=1.
  - mem_we_o[b]=1 only for a wr grant.
  - mem_addr/mem_wdata are muxed from the winner.
  - Ungranted banks have en=0; their addr/wdata are don't-care, driven 0.
- Read return, latency 1:
  - pre_vld_o is registered pre_ack_o, and the granted bank index is registered too.
  - pre_data_o = mem_rdata_i slice of the registered bank when pre_vld_o=1, else 0.
  - ec path is identical.
  - Back-to-back reads are supported at one per cycle per requester.
- Requester must hold req/bank/addr(/data) stable until ack. Changing them before ack is illegal and unchecked.
- Reset mid-operation: in-flight read vld is dropped (vld=0 in cycle after rst). No memory write is issued during rst.

Optional Feature:
- Macro REC_ARB_OUT_REG_EN.
- When defined:
  - pre_data_o/ec_data_o and the vld outputs pass through one extra register stage, so read latency becomes 2 cycles (vld two cycles after ack).
  - The data register holds 0 when its vld is 0, and clears on rst.
- When undefined, latency is 1 as specified above.
- Grant logic is unaffected either way.

Test Plan:
- wr, pre and ec all request bank 2 in the same cycle after reset: wr_ack_o=1, pre_ack_o=0, ec_ack_o=0. Next cycle (wr dropped): pre_ack_o=1. Following cycle: ec_ack_o=1.
- pre on bank 0 addr 5, ec on bank 1 addr 9, wr on bank 3, same cycle: all three acks=1; mem_en_o=4'b1011; mem_we_o=4'b1000. One cycle later pre_vld_o=1 with the bank-0 rdata, and ec_vld_o=1 with the bank-1 rdata.
- wr held continuously on bank 1 while pre requests bank 1 (STARVE_MAX=4): pre refused 4 cycles. In the 5th cycle pre_ack_o=1 and wr_ack_o=0. The next cycle wr_ack_o=1.
- pre and ec both continuously on bank 0 for 6 cycles: grants alternate pre, ec, pre, ec, pre, ec; rr_r[0] toggles each cycle.
- pre read granted, then rst asserted the next cycle: pre_vld_o=0 and all acks=0 during rst. After release, rr_r=0 and stv counters=0.
- With REC_ARB_OUT_REG_EN defined: ec read of bank 2 granted at cycle t gives ec_vld_o=1 at t+2 carrying the bank-2 rdata sampled at t+1; ec_vld_o=0 at t+1.
